riscv_pc_gen: RTL
=================

RISCV_PC_GEN -- requirements
Module: riscv_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits[1:0] SHALL be 0.
REQ-002 Parameter TRAP_ALIGN_MASK, default 32'hFFFF_FFFC: AND-mask applied to trap vectors.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_stall_i  input  1  downstream stall; hold current PC.
REQ-006 pc_redirect_i  input  1  taken branch/jump this cycle.
REQ-007 pc_redirect_addr_i  input  32  branch/jump target.
REQ-008 pc_trap_i  input  1  trap/exception entry request.
REQ-009 pc_trap_vector_i  input  32  trap handler address.
REQ-010 pc_o  output  32  current fetch PC, fed to instruction memory stage PC input.
REQ-011 pc_valid_o  output  1  pc_o is a legal fetch address this cycle.
REQ-012 pc_plus4_o  output  32  pc_o + 4, modulo 2^32, for link-register writeback.
REQ-013 pc_fault_o  output  1  misaligned redirect captured; fetch halted.
REQ-014 pc_fault_addr_o  output  32  offending redirect target.
REQ-015 pc_fetch_cnt_o  output  32  count of advancing fetch cycles.

Function
REQ-016 FSM states BOOT, RUN, FAULT; next-state and PC update evaluated once per posedge clk.
REQ-017 BOOT: entered on reset; pc_valid_o=0; pc_o=RESET_PC; unconditionally -> RUN next cycle, PC unchanged.
REQ-018 RUN: pc_valid_o=1; next PC priority trap > redirect > stall > increment.
REQ-019 Trap in RUN or FAULT: next PC = pc_trap_vector_i & TRAP_ALIGN_MASK; state -> RUN; pc_fault_o cleared.
REQ-020 Redirect in RUN with target[1:0]==0: next PC = pc_redirect_addr_i, even when pc_stall_i=1.
REQ-021 Redirect in RUN with target[1:0]!=0: PC held; pc_fault_addr_o <= target; state -> FAULT.
REQ-022 Stall in RUN, no trap/redirect: PC held; counter held.
REQ-023 Increment: next PC = pc_o + 4; 32'hFFFF_FFFC wraps to 32'h0000_0000; no flag.
REQ-024 FAULT: pc_valid_o=0; pc_fault_o=1; PC and pc_fault_addr_o frozen; pc_redirect_i and pc_stall_i ignored; exit only via trap.
REQ-025 pc_fetch_cnt_o increments by 1 each cycle in RUN with pc_valid_o=1 and next PC from increment or redirect; wraps at 2^32.
REQ-026 Trap and redirect asserted same cycle: trap wins; redirect address not checked for alignment.
REQ-027 pc_plus4_o combinational from pc_o; valid in all states.
REQ-028 Inputs in BOOT ignored, including trap.

Reset
REQ-029 reset sampled at posedge clk only; reset overrides all other inputs.
REQ-030 Reset values: state=BOOT, pc_o=RESET_PC, pc_valid_o=0, pc_fault_o=0, pc_fault_addr_o=0, pc_fetch_cnt_o=0.
REQ-031 Reset asserted mid-RUN or in FAULT: next cycle in BOOT; no partial update retained.

Structure
REQ-032 FSM state enum (pc_state_t: BOOT, RUN, FAULT) and constant PC_INCR=32'd4 reside in shared package riscv_pkg.
REQ-033 Single module, no sub-module; one sequential block for PC/state/counter, one combinational next-PC block.

Verification
REQ-034 Reset released, no inputs, 4 cycles -> pc_o 0,0,4,8; pc_valid_o 0,1,1,1; cnt 0,0,1,2.
REQ-035 RUN at 0x10, pc_stall_i=1 for 3 cycles -> pc_o stays 0x10, cnt frozen; release -> 0x14.
REQ-036 RUN at 0x20, stall=1 and redirect to 0x100 same cycle -> next pc_o=0x100, cnt+1.
REQ-037 Redirect to 0x102 -> pc_fault_o=1, pc_fault_addr_o=0x102, pc_valid_o=0, PC held; later redirect ignored; trap vector 0x207 -> pc_o=0x204, RUN.
REQ-038 PC=0xFFFF_FFFC, increment -> pc_o=0x0000_0000, pc_plus4_o=0x4; trap+redirect(0x300) with vector 0x80 -> pc_o=0x80.
REQ-039 Reset asserted one cycle while in FAULT -> BOOT, pc_o=RESET_PC, pc_fault_o=0, cnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch PC generator.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Sequential fetch step in bytes.
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  // PC generator operating mode.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  // A fetch target is legal only on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage : riscv_pkg

// File: rtl/riscv_pc_gen.sv
// Fetch PC generator: boot sequencing, trap/redirect/stall/increment selection,
// misaligned-redirect fault capture and an advancing-fetch counter.
module riscv_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_stall_i,
  input  logic            pc_redirect_i,
  input  logic [XLEN-1:0] pc_redirect_addr_i,
  input  logic            pc_trap_i,
  input  logic [XLEN-1:0] pc_trap_vector_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_fault_o,
  output logic [XLEN-1:0] pc_fault_addr_o,
  output logic [XLEN-1:0] pc_fetch_cnt_o
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;

  // Next-state, next-PC, fault capture and counter selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    fetch_cnt_d  = fetch_cnt_q;

    unique case (state_q)
      BOOT: begin
        // All inputs, trap included, are ignored while booting.
        state_d = RUN;
      end

      RUN: begin
        if (pc_trap_i) begin
          // Trap wins over redirect; the redirect target is not inspected.
          pc_d = pc_trap_vector_i & TRAP_ALIGN_MASK;
        end else if (pc_redirect_i) begin
          if (is_word_aligned(pc_redirect_addr_i)) begin
            // Redirect overrides a concurrent stall.
            pc_d        = pc_redirect_addr_i;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end else begin
            fault_addr_d = pc_redirect_addr_i;
            state_d      = FAULT;
          end
        end else if (!pc_stall_i) begin
          pc_d        = pc_q + PC_INCR;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end

      FAULT: begin
        // Frozen until a trap vectors fetch back into a handler.
        if (pc_trap_i) begin
          pc_d    = pc_trap_vector_i & TRAP_ALIGN_MASK;
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // State, PC, fault address and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      fault_addr_q <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = (state_q == RUN);
  assign pc_fault_o      = (state_q == FAULT);
  assign pc_fault_addr_o = fault_addr_q;
  assign pc_fetch_cnt_o  = fetch_cnt_q;
  assign pc_plus4_o      = pc_q + PC_INCR;

endmodule : riscv_pc_gen
